// File: rtl/cacheline_burst_adaptor_if.sv
// cacheline_burst_adaptor_if: cache-side line port and memory-side burst port of the adaptor.
interface cacheline_burst_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic               err_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;
    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
    );
    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns one cache line read/write into a BEATS-beat memory burst.
// Defining CACHELINE_BURST_TIMEOUT_EN adds a stall watchdog that aborts the burst with err_o.
module cacheline_burst_adaptor #(
    parameter int LINE_W      = 256,
    parameter int BURST_W     = 64,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic clk,
    input logic rst,
    cacheline_burst_adaptor_if.slave bus
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wr_line_q;
    logic [LINE_W-1:0]  rd_line_q;
    logic               in_burst;
    logic               beat;
    logic               last_beat;
    logic               timeout;
    logic               err_q;

    assign in_burst  = state_q == RD_BURST || state_q == WR_BURST;
    assign beat      = in_burst && bus.resp_i;
    assign last_beat = beat && cnt_q == CNT_W'(BEATS - 1);

`ifdef CACHELINE_BURST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    // wd_q counts stalls seen so far; this cycle's stall is the one that reaches the limit
    assign timeout = in_burst && !bus.resp_i && wd_q == WD_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (in_burst && !bus.resp_i) ? wd_q + 1'b1 : '0;
            err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:               state_d = bus.write_i ? WR_BURST : bus.read_i ? RD_BURST : IDLE;
            RD_BURST, WR_BURST: state_d = (last_beat || timeout) ? DONE : state_q;
            default:            state_d = IDLE;
        endcase
        bus.read_o  = state_q == RD_BURST;
        bus.write_o = state_q == WR_BURST;
        bus.resp_o  = state_q == DONE;
        bus.err_o   = state_q == DONE && err_q;
        bus.burst_o = state_q == WR_BURST ? wr_line_q[BURST_W*cnt_q +: BURST_W] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
        end else begin
            if (state_q == IDLE && (bus.write_i || bus.read_i)) begin
                cnt_q  <= '0;
                addr_q <= bus.address_i & ALIGN_MASK;
            end
            if (state_q == IDLE && bus.write_i) wr_line_q <= bus.line_i;
            if (beat) cnt_q <= cnt_q + 1'b1;
            if (beat && state_q == RD_BURST) rd_line_q[BURST_W*cnt_q +: BURST_W] <= bus.burst_i;
        end
    end

    assign bus.address_o = addr_q;
    assign bus.line_o    = rd_line_q;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: line read/write transactions against a beat-level memory model.
module tb_cacheline_burst_adaptor;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int TO      = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    logic [LINE_W-1:0] last_line = '0;

    cacheline_burst_adaptor_if bus();
    cacheline_burst_adaptor #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, LINE_W'({bus.resp_o, bus.err_o, bus.read_o, bus.write_o}), '0);
        check({tag, "_addr"}, LINE_W'(bus.address_o), '0);
        check({tag, "_burst"}, LINE_W'(bus.burst_o), '0);
        check({tag, "_line"}, bus.line_o, '0);
    endtask

    // mode: 0 no stalls, 1 random stalls, 2 three stalls before beat 2; abort_at = beat index to reset at
    task automatic txn(input bit wr, input bit both, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] data, input int mode, input int abort_at);
        logic [ADDR_W-1:0] exp_addr;
        int beats, stalls, cyc, wcyc;
        bit done, stall;
        exp_addr = addr & ~32'h1f;
        beats = 0; stalls = 0; cyc = 0; wcyc = 0; done = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.address_i = addr;
        bus.line_i    = wr ? data : rand_line();
        bus.write_i   = wr;
        bus.read_i    = !wr || both;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_o) begin
                done = 1;
                check("resp_cycle", LINE_W'(cyc), LINE_W'(1 + BEATS + stalls));
                check("err_o", LINE_W'(bus.err_o), '0);
                check("beat_count", LINE_W'(beats), LINE_W'(BEATS));
                if (wr) check("write_cycles", LINE_W'(wcyc), LINE_W'(BEATS + stalls));
                else last_line = data;
                check("line_o", bus.line_o, last_line);
                check("done_bus_idle", LINE_W'({bus.read_o, bus.write_o}), '0);
            end else begin
                check(wr ? "write_o" : "read_o", LINE_W'({bus.read_o, bus.write_o}), LINE_W'(wr ? 2'b01 : 2'b10));
                check("address_o", LINE_W'(bus.address_o), LINE_W'(exp_addr));
                if (wr) begin
                    wcyc++;
                    check("burst_o", LINE_W'(bus.burst_o), LINE_W'(data[BURST_W*beats +: BURST_W]));
                end
                if (beats == abort_at) begin
                    #2 rst = 1'b0;
                    #1 check_reset_outputs("async_rst");
                    last_line = '0;
                    bus.resp_i = 1'b0;
                    return;
                end
                stall = mode == 1 ? ($urandom_range(3) == 0) : mode == 2 ? (beats == 2 && stalls < 3) : 1'b0;
                bus.resp_i  = !stall;
                bus.burst_i = stall ? {$urandom, $urandom} : data[BURST_W*beats +: BURST_W];
                if (stall) stalls++;
                else beats++;
            end
        end
        if (!done) check("resp_seen", '0, LINE_W'(1));
        @(negedge clk);
        check("idle_after_done", LINE_W'({bus.resp_o, bus.read_o, bus.write_o}), '0);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'($urandom);
        bus.burst_i = {$urandom, $urandom};
        @(negedge clk);
        check("no_retrigger", LINE_W'({bus.resp_o, bus.read_o, bus.write_o}), '0);
    endtask

    initial begin
        int first;
        bit errv;
        logic [LINE_W-1:0] d;
        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        txn(0, 0, 32'h0000_1234, {64'h4444444444444444, 64'h3333333333333333,
                                  64'h2222222222222222, 64'h1111111111111111}, 0, -1);
        check("plan_address", LINE_W'(bus.address_o), LINE_W'(32'h0000_1220));
        txn(1, 0, 32'h0000_8000, {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                  64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA}, 2, -1);
        txn(1, 1, $urandom, rand_line(), 1, -1);
        txn(0, 0, $urandom, rand_line(), 1, -1);
        d = rand_line();
        txn(0, 0, 32'h0000_4444, d, 0, 2);
        txn(0, 0, 32'h0000_4444, rand_line(), 0, -1);
        @(negedge clk);
        bus.read_i = 1'b1; bus.write_i = 1'b0; bus.address_i = $urandom; bus.resp_i = 1'b0;
        first = 0; errv = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.resp_o && first == 0) begin
                first = i;
                errv  = bus.err_o;
                check("timeout_line", bus.line_o, last_line);
            end
        end
`ifdef CACHELINE_BURST_TIMEOUT_EN
        check("timeout_cycle", LINE_W'(first), LINE_W'(TO + 1));
        check("timeout_err", LINE_W'(errv), LINE_W'(1));
`else
        check("no_timeout_resp", LINE_W'(first), '0);
        check("still_reading", LINE_W'(bus.read_o), LINE_W'(1));
`endif
        bus.read_i = 1'b0;
        rst = 1'b0;
        last_line = '0;
        for (int n = 0; n < 40; n++)
            txn(1'($urandom), $urandom_range(3) == 0, $urandom, rand_line(), 1, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
